// File: rtl/emu_phase_ctrl.sv
// rtl/emu_phase_ctrl.sv - emulation run sequencer: warm-up, tagged measurement batch, drain, latency accounting
module emu_phase_ctrl #(
  parameter int PORTS         = 16,
  parameter int WARMUP_PKTS   = 1000,
  parameter int MEASURE_PKTS  = 5000,
  parameter int DRAIN_TIMEOUT = 100000,
  parameter int LAT_W         = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PORTS-1:0]       inj_valid,
  input  logic [PORTS-1:0]       ej_valid,
  input  logic [PORTS-1:0]       ej_measure,
  input  logic [PORTS*LAT_W-1:0] ej_latency,
  output logic                   src_enable,
  output logic                   measure_tag,
  output logic [2:0]             phase,
  output logic [31:0]            meas_injected,
  output logic [31:0]            meas_ejected,
  output logic [47:0]            latency_sum,
  output logic                   done,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } phase_t;

  localparam logic [31:0] WARMUP_LIM  = 32'(WARMUP_PKTS);
  localparam logic [31:0] MEASURE_LIM = 32'(MEASURE_PKTS);
  localparam logic [31:0] DRAIN_LAST  = 32'(DRAIN_TIMEOUT - 1);

  phase_t      state_q, state_d;
  logic [31:0] warm_cnt_q, warm_cnt_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic [31:0] inj_cnt_d, ej_cnt_d;
  logic [47:0] lat_sum_d;
  logic        timeout_d;

  logic [31:0] inj_n;
  logic [31:0] ej_n;
  logic [47:0] ej_lat;

  // Per-cycle injection count and tagged-ejection count/latency across all ports.
  always_comb begin
    inj_n  = '0;
    ej_n   = '0;
    ej_lat = '0;
    for (int k = 0; k < PORTS; k++) begin
      inj_n = inj_n + 32'(inj_valid[k]);
      if (ej_valid[k] && ej_measure[k]) begin
        ej_n   = ej_n + 32'd1;
        ej_lat = ej_lat + 48'(ej_latency[k*LAT_W +: LAT_W]);
      end
    end
  end

  logic [31:0] warm_total, inj_total, ej_total;
  logic [47:0] lat_total;

  assign warm_total = warm_cnt_q + inj_n;
  assign inj_total  = meas_injected + inj_n;
  assign ej_total   = meas_ejected + ej_n;
  assign lat_total  = latency_sum + ej_lat;

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    drain_cnt_d = drain_cnt_q;
    inj_cnt_d   = meas_injected;
    ej_cnt_d    = meas_ejected;
    lat_sum_d   = latency_sum;
    timeout_d   = timeout;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WARMUP;
          warm_cnt_d  = '0;
          drain_cnt_d = '0;
          inj_cnt_d   = '0;
          ej_cnt_d    = '0;
          lat_sum_d   = '0;
          timeout_d   = 1'b0;
        end
      end
      S_WARMUP: begin
        ej_cnt_d   = ej_total;
        lat_sum_d  = lat_total;
        warm_cnt_d = warm_total;
        if (warm_total >= WARMUP_LIM) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        ej_cnt_d  = ej_total;
        lat_sum_d = lat_total;
        inj_cnt_d = inj_total;
        if (inj_total >= MEASURE_LIM) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        ej_cnt_d    = ej_total;
        lat_sum_d   = lat_total;
        drain_cnt_d = drain_cnt_q + 32'd1;
        // Exact match only: an over-ejecting sink must not end the batch early.
        if (ej_total == meas_injected) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      warm_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      meas_injected <= '0;
      meas_ejected  <= '0;
      latency_sum   <= '0;
      timeout       <= 1'b0;
      src_enable    <= 1'b0;
      measure_tag   <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_cnt_q    <= warm_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      meas_injected <= inj_cnt_d;
      meas_ejected  <= ej_cnt_d;
      latency_sum   <= lat_sum_d;
      timeout       <= timeout_d;
      src_enable    <= (state_d == S_WARMUP) || (state_d == S_MEASURE) || (state_d == S_DRAIN);
      measure_tag   <= (state_d == S_MEASURE);
      done          <= (state_d == S_DONE);
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_emu_phase_ctrl.sv
// tb/tb_emu_phase_ctrl.sv - self-checking bench for emu_phase_ctrl against a run-level reference model
module tb_emu_phase_ctrl;
  localparam int PORTS = 4;
  localparam int LAT_W = 24;
  localparam int WARM  = 8;
  localparam int MEAS  = 8;
  localparam int TO    = 50;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [PORTS-1:0]       inj_valid, ej_valid, ej_measure;
  logic [PORTS*LAT_W-1:0] ej_latency;
  logic                   src_enable, measure_tag, done, timeout;
  logic [2:0]             phase;
  logic [31:0]            meas_injected, meas_ejected;
  logic [47:0]            latency_sum;

  emu_phase_ctrl #(
    .PORTS(PORTS), .WARMUP_PKTS(WARM), .MEASURE_PKTS(MEAS),
    .DRAIN_TIMEOUT(TO), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .inj_valid(inj_valid), .ej_valid(ej_valid), .ej_measure(ej_measure),
    .ej_latency(ej_latency), .src_enable(src_enable), .measure_tag(measure_tag),
    .phase(phase), .meas_injected(meas_injected), .meas_ejected(meas_ejected),
    .latency_sum(latency_sum), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus run totals, advanced once per clock.
  int     m_phase = 0;
  longint m_warm = 0, m_inj = 0, m_ej = 0, m_lat = 0, m_dcyc = 0;
  bit     m_to = 0;

  always @(posedge clk) begin : model
    int     inj_n, ej_n;
    longint lat;
    inj_n = $countones(inj_valid);
    ej_n  = 0;
    lat   = 0;
    for (int k = 0; k < PORTS; k++) begin
      if (ej_valid[k] && ej_measure[k]) begin
        ej_n++;
        lat += longint'(ej_latency[k*LAT_W +: LAT_W]);
      end
    end
    if (rst) begin
      m_phase = 0; m_warm = 0; m_inj = 0; m_ej = 0; m_lat = 0; m_dcyc = 0; m_to = 0;
    end else begin
      if (m_phase >= 1 && m_phase <= 3) begin
        m_ej  += ej_n;
        m_lat += lat;
      end
      case (m_phase)
        0, 4: if (start) begin
          m_phase = 1; m_warm = 0; m_inj = 0; m_ej = 0; m_lat = 0; m_dcyc = 0; m_to = 0;
        end
        1: begin
          m_warm += inj_n;
          if (m_warm >= WARM) m_phase = 2;
        end
        2: begin
          m_inj += inj_n;
          if (m_inj >= MEAS) begin m_phase = 3; m_dcyc = 0; end
        end
        3: begin
          m_dcyc++;
          if (m_ej == m_inj) m_phase = 4;
          else if (m_dcyc == TO) begin m_phase = 4; m_to = 1; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("phase", phase, m_phase);
    chk("src_enable", src_enable, (m_phase >= 1 && m_phase <= 3));
    chk("measure_tag", measure_tag, (m_phase == 2));
    chk("done", done, (m_phase == 4));
    chk("timeout", timeout, m_to);
    chk("meas_injected", meas_injected, m_inj[31:0]);
    chk("meas_ejected", meas_ejected, m_ej[31:0]);
    chk("latency_sum", latency_sum, m_lat[47:0]);
  end

  function automatic logic [PORTS*LAT_W-1:0] lat_all(input logic [LAT_W-1:0] v);
    return {PORTS{v}};
  endfunction

  task automatic drive(input logic [PORTS-1:0] iv, input logic [PORTS-1:0] ev,
                       input logic [PORTS-1:0] em, input logic [PORTS*LAT_W-1:0] lat,
                       input logic st);
    inj_valid = iv; ej_valid = ev; ej_measure = em; ej_latency = lat; start = st;
    @(negedge clk);
  endtask

  task automatic start_to_drain(input string tag);
    drive('0, '0, '0, '0, 1'b1);
    chk({tag, "_warmup"}, phase, 1);
    drive('1, '0, '0, '0, 1'b0);
    chk({tag, "_warmup2"}, phase, 1);
    drive('1, '0, '0, '0, 1'b0);
    chk({tag, "_measure"}, phase, 2);
    drive('1, '0, '0, '0, 1'b0);
    chk({tag, "_minj4"}, meas_injected, 4);
    drive('1, '0, '0, '0, 1'b0);
    chk({tag, "_drain"}, phase, 3);
    chk({tag, "_minj8"}, meas_injected, 8);
  endtask

  task automatic basic_run(input string tag);
    start_to_drain(tag);
    for (int i = 0; i < 4; i++) drive('1, 4'b0011, 4'b0011, lat_all(24'd10), 1'b0);
    chk({tag, "_done_phase"}, phase, 4);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ej"}, meas_ejected, 8);
    chk({tag, "_lat"}, latency_sum, 80);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_src_off"}, src_enable, 0);
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [PORTS-1:0]       iv, ev, em;
    logic [PORTS*LAT_W-1:0] lat;
    longint                 rem;
    rst = 1'b1; start = 1'b0; inj_valid = '0; ej_valid = '0; ej_measure = '0; ej_latency = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_phase", phase, 0);
    chk("reset_minj", meas_injected, 0);
    chk("reset_src", src_enable, 0);

    basic_run("t1");

    // Filtering in DONE: neither tagged nor untagged ejections move the totals.
    drive('0, '1, '1, lat_all(24'd7), 1'b0);
    drive('0, '1, '0, lat_all(24'd7), 1'b0);
    chk("t5_done_ej", meas_ejected, 8);
    chk("t5_done_lat", latency_sum, 80);

    // Overshoot, with a start pulse that MEASURE must ignore.
    drive('0, '0, '0, '0, 1'b1);
    drive('1, '0, '0, '0, 1'b0);
    drive('1, '0, '0, '0, 1'b0);
    drive(4'b0111, '0, '0, '0, 1'b1);
    chk("t5_start_ignored", phase, 2);
    chk("t2_minj3", meas_injected, 3);
    drive('1, '0, '0, '0, 1'b0);
    chk("t2_minj7", meas_injected, 7);
    drive('1, '0, '0, '0, 1'b0);
    chk("t2_minj11", meas_injected, 11);
    chk("t2_drain", phase, 3);
    drive('1, '1, '1, lat_all(24'(32'($urandom))), 1'b0);
    drive('1, '1, 4'b0000, lat_all(24'd99), 1'b0);
    drive('1, '1, '1, lat_all(24'(32'($urandom))), 1'b0);
    drive('1, 4'b0011, 4'b0011, lat_all(24'd5), 1'b0);
    chk("t2_still_drain", phase, 3);
    chk("t2_ej10", meas_ejected, 10);
    drive('1, 4'b1000, 4'b1000, lat_all(24'd3), 1'b0);
    chk("t2_done", phase, 4);
    chk("t2_ej11", meas_ejected, 11);

    // Timeout: one tagged packet never arrives.
    start_to_drain("t3");
    drive('1, '1, '1, lat_all(24'd1), 1'b0);
    drive('1, 4'b0111, 4'b0111, lat_all(24'd1), 1'b0);
    for (int i = 2; i < TO - 1; i++) drive('1, '0, '0, '0, 1'b0);
    chk("t3_drain_49", phase, 3);
    drive('1, '0, '0, '0, 1'b0);
    chk("t3_done", phase, 4);
    chk("t3_timeout", timeout, 1);
    chk("t3_src_off", src_enable, 0);
    chk("t3_ej7", meas_ejected, 7);

    // Coincidence: final ejection lands on the last allowed drain cycle.
    start_to_drain("t4");
    drive('1, '1, '1, lat_all(24'd2), 1'b0);
    drive('1, 4'b0111, 4'b0111, lat_all(24'd2), 1'b0);
    for (int i = 2; i < TO - 1; i++) drive('1, '0, '0, '0, 1'b0);
    drive('1, 4'b0001, 4'b0001, lat_all(24'd2), 1'b0);
    chk("t4_done", phase, 4);
    chk("t4_timeout", timeout, 0);
    chk("t4_lat", latency_sum, 16);

    // Reset mid-MEASURE, then an identical fresh run.
    drive('0, '0, '0, '0, 1'b1);
    drive('1, '0, '0, '0, 1'b0);
    drive('1, '0, '0, '0, 1'b0);
    drive('1, '0, '0, '0, 1'b0);
    rst = 1'b1;
    drive('1, '1, '1, lat_all(24'd4), 1'b0);
    rst = 1'b0;
    chk("t6_rst_phase", phase, 0);
    chk("t6_rst_minj", meas_injected, 0);
    chk("t6_rst_mej", meas_ejected, 0);
    chk("t6_rst_lat", latency_sum, 0);
    chk("t6_rst_flags", {src_enable, measure_tag, done, timeout}, 0);
    basic_run("t6");
    drive('0, '0, '0, '0, 1'b1);
    chk("t6_restart_phase", phase, 1);
    chk("t6_restart_minj", meas_injected, 0);
    chk("t6_restart_mej", meas_ejected, 0);
    chk("t6_restart_lat", latency_sum, 0);

    // Randomized traffic; DRAIN ejections are mostly bounded by the outstanding count.
    for (int c = 0; c < 3000; c++) begin
      iv = PORTS'($urandom);
      ev = PORTS'($urandom);
      em = '0;
      for (int k = 0; k < PORTS; k++) lat[k*LAT_W +: LAT_W] = LAT_W'($urandom);
      if (phase == 3 && $urandom_range(0, 19) != 0) begin
        rem = m_inj - m_ej;
        for (int k = 0; k < PORTS; k++) begin
          if (rem > 0 && $urandom_range(0, 1) == 1) begin
            ev[k] = 1'b1; em[k] = 1'b1; rem--;
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        em = ev & PORTS'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      drive(iv, ev, em, lat,
            ((phase == 0 || phase == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0)));
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/emu_phase_ctrl.md
Name: emu_phase_ctrl

Overview:
Run controller for the mesh network emulation testbench. It sequences each run through warm-up, measurement and drain phases, and gates the packet sources. It also tags which injected packets belong to the measured batch. It accumulates ejection count and latency for tagged packets only, so that average latency is computed over a clean, fully drained batch. It sits between the packet sources/sinks and the network, alongside the timestamp counter, and replaces ad-hoc batch counting in the top level.

Parameters:
PORTS, 16, number of source/sink pairs (4x4 mesh).
WARMUP_PKTS, 1000, untagged packets injected before measurement starts.
MEASURE_PKTS, 5000, minimum number of tagged packets to inject.
DRAIN_TIMEOUT, 100000, cycles allowed in DRAIN before the run aborts.
LAT_W, 24, width of each per-packet latency value (matches timestamp width).

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  one-cycle pulse that begins a run
inj_valid  in  PORTS  bit k high = source k injected a packet this cycle
ej_valid  in  PORTS  bit k high = sink k received a packet this cycle
ej_measure  in  PORTS  measure flag of the packet at sink k (qualified by ej_valid[k])
ej_latency  in  PORTS*LAT_W  latency of the packet at sink k, port k at bits [k*LAT_W +: LAT_W]
src_enable  out  1  sources may generate packets
measure_tag  out  1  value sources write into the packet measure field
phase  out  3  IDLE=0, WARMUP=1, MEASURE=2, DRAIN=3, DONE=4
meas_injected  out  32  tagged packets injected
meas_ejected  out  32  tagged packets ejected
latency_sum  out  48  sum of ej_latency over tagged ejections
done  out  1  run complete, results stable
timeout  out  1  the drain timed out and the run was aborted

Behaviour:
- Interface: reset is rst, synchronous, active-high; the clock is clk. All outputs are registered.
- Reset values: phase=IDLE, src_enable=0, measure_tag=0, done=0, timeout=0, all counters 0. A reset mid-run aborts the run immediately. The next cycle after reset is IDLE.
- Per-cycle counts: inj_n = popcount(inj_valid); ej_n = popcount(ej_valid & ej_measure), at most PORTS. Counters are 32-bit; latency_sum is 48-bit; all add without saturation.
- src_enable=1 in WARMUP, MEASURE and DRAIN. measure_tag=1 only in MEASURE.
- IDLE: on start go to WARMUP and clear all counters and flags in the same edge.
- WARMUP: warm_cnt += inj_n. When warm_cnt+inj_n >= WARMUP_PKTS, go to MEASURE at that edge. If WARMUP_PKTS=0, WARMUP lasts exactly one cycle.
- MEASURE: meas_injected += inj_n. When meas_injected+inj_n >= MEASURE_PKTS, go to DRAIN. All injections in the crossing cycle are counted, so meas_injected may exceed MEASURE_PKTS by up to PORTS-1.
- DRAIN: sources keep injecting untagged traffic to hold the load steady. drain_cnt increments every cycle.
  - When meas_ejected (including this cycle's ej_n) == meas_injected, go to DONE.
  - Otherwise, when drain_cnt reaches DRAIN_TIMEOUT-1, go to DONE and set timeout=1.
- Tagged ejection accounting: active in WARMUP, MEASURE and DRAIN. meas_ejected += ej_n, and latency_sum += the sum of ej_latency[k] for every k with ej_valid[k] & ej_measure[k], same cycle. Ignored in IDLE and DONE.
- DONE: done=1, src_enable=0, counters frozen. start returns to WARMUP with everything cleared.
- start is ignored in WARMUP, MEASURE and DRAIN.
- Simultaneous events in DRAIN: if the drain-complete condition and the timeout condition occur in the same cycle, completion wins (timeout=0).
- meas_ejected > meas_injected can only come from a misbehaving sink. It is not a valid completion: DRAIN continues until timeout.
- Latency: state changes and output updates appear one cycle after the triggering inputs.

Test Plan:
1. Basic run. PORTS=4, WARMUP=8, MEASURE=8, TIMEOUT=50; start, then inj_valid=4'b1111 each cycle → 2 cycles in WARMUP, 2 in MEASURE, meas_injected=8. Eject 8 tagged packets, latency 10 each → DONE, meas_ejected=8, latency_sum=80, timeout=0.
2. Overshoot. In MEASURE with meas_injected=7, inject 4'b1111 → meas_injected=11 and phase=DRAIN the next cycle. DONE only after 11 tagged ejections.
3. Timeout. Same setup, eject only 7 of 8 tagged packets → after 50 DRAIN cycles phase=DONE, timeout=1, src_enable=0.
4. Coincidence. Final tagged ejection on the same cycle drain_cnt=49 → DONE with timeout=0.
5. Filtering. Ejections with ej_measure=0, and tagged ejections in DONE → meas_ejected and latency_sum unchanged. start during MEASURE → ignored.
6. Reset and restart. Assert rst during MEASURE → next cycle phase=0, all outputs 0. A new start runs case 1 again with identical results. start in DONE clears all counters.
